// File: rtl/jb_prach_fft_mem_read_if.sv
// AXI4-stream bundle carrying FFT input samples (tdata = {I,Q}, tuser = antenna id).
interface jb_axi4_stream_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 2
) ();
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/jb_prach_fft_mem_read.sv
// PRACH FFT sample-buffer read side: waits for one CP-stripped symbol in the FIFO, then
// streams it to the FFT core through a 2-entry skid buffer. Optional status: JB_PRACH_FFT_RD_STATUS_EN.
module jb_prach_fft_mem_read #(
  parameter int USR_ID_BW    = 2,
  parameter int PRECISION    = 16,
  parameter int MAX_FFT_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [MAX_FFT_LOG2:0]     fft_len,
  input  logic                      sub_frame_mrkr,
  input  logic [2*PRECISION-1:0]    fifo_rdata,
  input  logic [USR_ID_BW-1:0]      fifo_ruser,
  input  logic [MAX_FFT_LOG2:0]     fifo_count,
  input  logic                      fifo_empty,
  output logic                      fifo_rden,
  jb_axi4_stream_if.master          IFP_fft_out,
  output logic                      busy,
  output logic [3:0]                sym_cnt,
  output logic                      underflow
`ifdef JB_PRACH_FFT_RD_STATUS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               max_stall
`endif
);

  localparam int CW = MAX_FFT_LOG2 + 1;
  localparam int DW = 2 * PRECISION;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FILL,
    S_READ,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [CW-1:0]       len_q;
  logic [CW-1:0]       rd_cnt;
  logic [CW-1:0]       out_cnt;

  logic                rd_inflight;
  logic [DW-1:0]       skid_data [2];
  logic [USR_ID_BW-1:0] skid_user [2];
  logic                skid_wptr;
  logic                skid_rptr;
  logic [1:0]          skid_occ;

  logic                tvalid_i;
  logic                tlast_i;
  logic                beat;
  logic                last_beat;
  logic [1:0]          slots_used;
  logic                rd_issue;

  assign tvalid_i  = (skid_occ != 2'd0);
  assign tlast_i   = tvalid_i && (out_cnt == len_q - CW'(1));
  assign beat      = clk_en && tvalid_i && IFP_fft_out.tready;
  assign last_beat = beat && tlast_i;

  // Slots counted as they will stand after this cycle's pop, so a steady tready=1 never bubbles.
  assign slots_used = skid_occ + {1'b0, rd_inflight} - {1'b0, beat};

  assign rd_issue = reset && clk_en && (state == S_READ) && (rd_cnt < len_q)
                    && (slots_used < 2'd2) && !fifo_empty;
  assign fifo_rden = rd_issue;

  assign IFP_fft_out.tvalid = tvalid_i;
  assign IFP_fft_out.tdata  = skid_data[skid_rptr];
  assign IFP_fft_out.tuser  = skid_user[skid_rptr];
  assign IFP_fft_out.tlast  = tlast_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      len_q   <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      busy    <= 1'b0;
    end else if (clk_en) begin
      if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
      if (beat)     out_cnt <= out_cnt + CW'(1);
      if (last_beat) busy <= 1'b0;
      case (state)
        S_IDLE: begin
          len_q <= fft_len;
          if (fft_len != '0) state <= S_WAIT_FILL;
        end
        S_WAIT_FILL: begin
          if (fifo_count >= len_q) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_READ;
          end
        end
        S_READ: begin
          if (rd_cnt == len_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_cnt == len_q) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO data is valid the cycle after the strobe; rd_inflight marks that capture slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_inflight <= 1'b0;
      skid_wptr   <= 1'b0;
      skid_rptr   <= 1'b0;
      skid_occ    <= 2'd0;
    end else if (clk_en) begin
      rd_inflight <= rd_issue;
      if (rd_inflight) skid_wptr <= ~skid_wptr;
      if (beat)        skid_rptr <= ~skid_rptr;
      case ({rd_inflight, beat})
        2'b10:   skid_occ <= skid_occ + 2'd1;
        2'b01:   skid_occ <= skid_occ - 2'd1;
        default: skid_occ <= skid_occ;
      endcase
    end
  end

  // NOTE: skid storage has no reset; occupancy alone decides validity, so its contents never matter when empty.
  always_ff @(posedge clk) begin
    if (clk_en && rd_inflight) begin
      skid_data[skid_wptr] <= fifo_rdata;
      skid_user[skid_wptr] <= fifo_ruser;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_cnt   <= 4'd0;
      underflow <= 1'b0;
    end else if (clk_en) begin
      if (rd_issue && fifo_empty) underflow <= 1'b1;
      if (sub_frame_mrkr)
        sym_cnt <= 4'd0;
      else if (last_beat && sym_cnt != 4'hF)
        sym_cnt <= sym_cnt + 4'd1;
    end
  end

`ifdef JB_PRACH_FFT_RD_STATUS_EN
  logic [15:0] stall_run;
  logic [15:0] stall_inc;

  assign stall_inc = (stall_run == 16'hFFFF) ? 16'hFFFF : stall_run + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= 16'd0;
      max_stall <= 16'd0;
      stall_run <= 16'd0;
    end else if (clk_en) begin
      if (last_beat) frame_cnt <= frame_cnt + 16'd1;
      if (tvalid_i && !IFP_fft_out.tready) begin
        stall_run <= stall_inc;
        if (stall_inc > max_stall) max_stall <= stall_inc;
      end else begin
        stall_run <= 16'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jb_prach_fft_mem_read.sv
// Scoreboard bench for jb_prach_fft_mem_read: a FIFO responder feeds indexed samples and a
// negedge monitor pops expected beats whenever the DUT hands one over.
module tb_jb_prach_fft_mem_read;

  localparam int CW = 13;
  localparam int DW = 32;
  localparam int UW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b1;
  logic          sub_frame_mrkr = 1'b0;
  logic          fifo_empty = 1'b0;
  logic [CW-1:0] fft_len = '0;
  logic [CW-1:0] fifo_count = '0;
  logic [DW-1:0] fifo_rdata = '0;
  logic [UW-1:0] fifo_ruser = '0;
  logic          tready = 1'b0;
  logic          fifo_rden;
  logic          busy;
  logic          underflow;
  logic [3:0]    sym_cnt;
`ifdef JB_PRACH_FFT_RD_STATUS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   max_stall;
`endif

  jb_axi4_stream_if #(.DATA_W(DW), .USER_W(UW)) fft_if ();

  logic          tvalid;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  assign fft_if.tready = tready;
  assign tvalid = fft_if.tvalid;
  assign tlast  = fft_if.tlast;
  assign tdata  = fft_if.tdata;
  assign tuser  = fft_if.tuser;

  jb_prach_fft_mem_read #(
    .USR_ID_BW   (UW),
    .PRECISION   (16),
    .MAX_FFT_LOG2(12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .fft_len       (fft_len),
    .sub_frame_mrkr(sub_frame_mrkr),
    .fifo_rdata    (fifo_rdata),
    .fifo_ruser    (fifo_ruser),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .fifo_rden     (fifo_rden),
    .IFP_fft_out   (fft_if),
    .busy          (busy),
    .sym_cnt       (sym_cnt),
    .underflow     (underflow)
`ifdef JB_PRACH_FFT_RD_STATUS_EN
    ,
    .frame_cnt     (frame_cnt),
    .max_stall     (max_stall)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    gen_idx = 0;
  int    exp_idx = 0;
  int    rd_pulses = 0;
  int    cyc = 0;
  int    frame_beats = 0;
  int    n_tlast = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;
  int    exp_sym = 0;

  function automatic logic [DW-1:0] sample(input int idx);
    return 32'hA500_0000 + 32'(idx);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (busy !== val && n < 20000) begin
      tick(1);
      n++;
    end
    check(name, 64'(busy), 64'(val));
  endtask

  task automatic push_frame(input int len);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = sample(exp_idx);
      e.user = exp_idx[UW-1:0];
      e.last = (i == len - 1);
      exp_q.push_back(e);
      exp_idx++;
    end
  endtask

  task automatic run_frame(input int len, input int next_len);
    push_frame(len);
    frame_beats = 0;
    fifo_count  = CW'(len);
    wait_busy(1'b1, "frame_start");
    fifo_count = '0;
    fft_len    = CW'(next_len);
    wait_busy(1'b0, "frame_end");
    tick(3);
    check("frame_beats", 64'(frame_beats), 64'(len));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (exp_sym < 15) exp_sym++;
    check("sym_cnt", 64'(sym_cnt), 64'(exp_sym));
  endtask

  // FIFO responder: data for a strobe appears the cycle after it.
  initial begin
    logic rd_now;
    forever begin
      @(negedge clk);
      rd_now = fifo_rden && clk_en;
      @(posedge clk);
      #1;
      if (rd_now) begin
        fifo_rdata = sample(gen_idx);
        fifo_ruser = gen_idx[UW-1:0];
        gen_idx++;
        rd_pulses++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    beat_t         e;
    logic          prev_stall;
    logic [35:0]   prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (reset && prev_stall)
        check("stall_hold", 64'({tvalid, tdata, tuser, tlast}), 64'(prev_out));
      if (reset && tvalid)
        check("skid_occ_le2", 64'(dut.skid_occ <= 2'd2), 64'd1);
      if (reset && clk_en && tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got %0h, expected no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({tdata, tuser, tlast}), 64'(e));
        end
        frame_beats++;
        if (tlast) begin
          n_tlast++;
          last_cyc = cyc;
        end
      end
      prev_stall = reset && tvalid && !(tready && clk_en);
      prev_out   = {tvalid, tdata, tuser, tlast};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state and fft_len=0 keeps the block idle even with a full FIFO.
    tick(3);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rden", 64'(fifo_rden), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_sym_cnt", 64'(sym_cnt), 64'd0);
    reset      = 1'b1;
    fifo_count = 13'd2000;
    tick(6);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_tvalid", 64'(tvalid), 64'd0);
    check("len0_rden", 64'(fifo_rden), 64'd0);
    fifo_count = '0;
    fft_len    = 13'd1024;
    tick(2);

    // 1024-sample frame with slow fill, then continuous tready.
    tready = 1'b1;
    rd_pulses = 0;
    frame_beats = 0;
    n_tlast = 0;
    push_frame(1024);
    for (int v = 0; v < 1024; v += 256) begin
      fifo_count = CW'(v);
      tick(4);
      check("fill_wait_tvalid", 64'(tvalid), 64'd0);
    end
    fifo_count = 13'd1023;
    tick(4);
    check("fill_1023_tvalid", 64'(tvalid), 64'd0);
    fifo_count = 13'd1024;
    tick(1);
    check("lat_cycle1_tvalid", 64'(tvalid), 64'd0);
    check("lat_cycle1_busy", 64'(busy), 64'd1);
    tick(1);
    check("lat_cycle2_tvalid", 64'(tvalid), 64'd0);
    tick(1);
    check("lat_cycle3_tvalid", 64'(tvalid), 64'd1);
    first_cyc  = cyc;
    fifo_count = '0;
    fft_len    = 13'd64;
    wait_busy(1'b0, "f1024_end");
    tick(3);
    check("f1024_no_bubble", 64'(last_cyc - first_cyc), 64'd1023);
    check("f1024_rden_pulses", 64'(rd_pulses), 64'd1024);
    check("f1024_beats", 64'(frame_beats), 64'd1024);
    check("f1024_tlast_count", 64'(n_tlast), 64'd1);
    check("f1024_sym_cnt", 64'(sym_cnt), 64'd1);
    check("f1024_underflow", 64'(underflow), 64'd0);
    check("f1024_queue", 64'(exp_q.size()), 64'd0);
    exp_sym = 1;

    // 64-sample frame under random backpressure, a clk_en gap, and an ignored fft_len change.
    push_frame(64);
    frame_beats = 0;
    n_tlast = 0;
    fifo_count = 13'd64;
    wait_busy(1'b1, "f64_start");
    fifo_count = '0;
    fft_len    = 13'd4;
    n = 0;
    while (frame_beats < 64 && n < 3000) begin
      tready = ($urandom_range(0, 1) == 1);
      clk_en = !(n >= 20 && n < 24);
      #1;
      if (!clk_en) check("clk_en_rden_gate", 64'(fifo_rden), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    clk_en = 1'b1;
    tready = 1'b1;
    check("f64_beats", 64'(frame_beats), 64'd64);
    wait_busy(1'b0, "f64_end");
    tick(3);
    check("f64_tlast_count", 64'(n_tlast), 64'd1);
    check("f64_queue", 64'(exp_q.size()), 64'd0);
    exp_sym = 2;
    check("f64_sym_cnt", 64'(sym_cnt), 64'd2);

    // Short frames drive sym_cnt into saturation; the last sets up a length-1 frame.
    for (int i = 0; i < 14; i++)
      run_frame(4, (i == 13) ? 1 : 4);
    check("sym_saturated", 64'(sym_cnt), 64'd15);
    run_frame(1, 64);

    // Underflow: one strobe forced while the FIFO reports empty.
    push_frame(64);
    frame_beats = 0;
    fifo_count = 13'd64;
    wait_busy(1'b1, "uf_start");
    fifo_count = '0;
    fft_len    = 13'd16;
    tick(10);
    fifo_empty = 1'b1;
    force dut.rd_issue = 1'b1;
    tick(1);
    release dut.rd_issue;
    fifo_empty = 1'b0;
    check("underflow_set", 64'(underflow), 64'd1);
    wait_busy(1'b0, "uf_end");
    tick(3);
    check("underflow_sticky", 64'(underflow), 64'd1);
    check("uf_beats", 64'(frame_beats), 64'd64);
    check("uf_queue", 64'(exp_q.size()), 64'd0);

    // Two back-to-back frames; sub_frame_mrkr lands on the second tlast.
    push_frame(16);
    push_frame(16);
    fifo_count = 13'd32;
    wait_busy(1'b1, "b2b_first_start");
    wait_busy(1'b0, "b2b_first_end");
    wait_busy(1'b1, "b2b_second_start");
    fifo_count = '0;
    fft_len    = 13'd1024;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (tvalid && tready && tlast) break;
      n++;
    end
    check("b2b_second_tlast_seen", 64'(n < 200), 64'd1);
    sub_frame_mrkr = 1'b1;
    @(posedge clk);
    #1;
    sub_frame_mrkr = 1'b0;
    check("mrkr_wins_over_tlast", 64'(sym_cnt), 64'd0);
    wait_busy(1'b0, "b2b_end");
    tick(3);
    check("b2b_queue", 64'(exp_q.size()), 64'd0);

    // Reset at beat 300 of 1024, then a clean frame.
    push_frame(1024);
    frame_beats = 0;
    fifo_count = 13'd1024;
    wait_busy(1'b1, "rst_frame_start");
    n = 0;
    while (frame_beats < 300 && n < 2000) begin
      tick(1);
      n++;
    end
    check("rst_at_beat300", 64'(frame_beats), 64'd300);
    reset = 1'b0;
    tick(1);
    check("midrst_tvalid", 64'(tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_underflow", 64'(underflow), 64'd0);
    check("midrst_sym_cnt", 64'(sym_cnt), 64'd0);
    exp_q.delete();
    exp_idx = gen_idx;
    push_frame(1024);
    frame_beats = 0;
    n_tlast = 0;
    reset = 1'b1;
    wait_busy(1'b1, "post_rst_start");
    fifo_count = '0;
    wait_busy(1'b0, "post_rst_end");
    tick(3);
    check("post_rst_beats", 64'(frame_beats), 64'd1024);
    check("post_rst_tlast_count", 64'(n_tlast), 64'd1);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);
    check("post_rst_sym_cnt", 64'(sym_cnt), 64'd1);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jb_prach_fft_mem_read.md
Name: jb_prach_fft_mem_read

Overview:
Read side of the PRACH FFT sample buffer. It waits until the buffer FIFO holds one complete CP-stripped symbol of fft_len samples, then drains exactly that many samples into the FFT core as an AXI4-stream frame with tlast on the final sample. It sits between the PRACH sample FIFO and the FFT core in the PRACH FFT top, and tolerates FFT-side backpressure through a 2-entry skid buffer.

Parameters:
USR_ID_BW, 2, width of tuser (antenna id)
PRECISION, 16, bits per I or Q component; tdata is 2*PRECISION
MAX_FFT_LOG2, 12, log2 of the largest supported FFT length; sets counter and fifo_count widths

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
clk_en  in  1  clock enable; all state updates are qualified by clk_en=1
fft_len  in  MAX_FFT_LOG2+1  samples per symbol; sampled in IDLE only
sub_frame_mrkr  in  1  sub-frame start pulse; resets sym_cnt
fifo_rdata  in  2*PRECISION  FIFO read data, valid 1 cycle after fifo_rden
fifo_ruser  in  USR_ID_BW  antenna id paired with fifo_rdata
fifo_count  in  MAX_FFT_LOG2+1  FIFO fill level
fifo_empty  in  1  FIFO empty
fifo_rden  out  1  FIFO read strobe
IFP_fft_out  jb_axi4_stream_if.master  -  tdata/tuser/tvalid/tready/tlast to the FFT core
busy  out  1  high from WAIT_FILL exit through the last output beat
sym_cnt  out  4  symbols emitted since the last sub_frame_mrkr; saturates at 15
underflow  out  1  sticky; set when fifo_rden is issued while fifo_empty=1

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; all counters=0; skid buffer empty; fifo_rden, tvalid, tlast, busy, underflow=0; sym_cnt=0. Reset mid-frame abandons the frame with no tlast. FIFO contents are not this block's responsibility.
- clk_en=0: all registers hold. fifo_rden=0 (combinational gate). tvalid holds its value and tdata is stable.
- States:
  - IDLE: latch fft_len into len_q. If fft_len=0, stay in IDLE. Otherwise go to WAIT_FILL.
  - WAIT_FILL: when fifo_count >= len_q, clear rd_cnt and out_cnt and go to READ.
  - READ: issue reads while rd_cnt < len_q, (skid occupancy + reads in flight) < 2, and fifo_empty=0. Each issued read increments rd_cnt. When rd_cnt = len_q, go to DRAIN.
  - DRAIN: wait until out_cnt = len_q (last beat accepted), then go to IDLE. Total of 2 cycles from last handshake back to IDLE readiness.
- Datapath: read data is captured into the skid buffer 1 cycle after fifo_rden. tvalid = skid buffer not empty. A beat transfers on tvalid and tready. out_cnt increments per beat. tlast=1 exactly on the beat with out_cnt = len_q-1. tuser is passed through with its sample.
- No bubbles when tready=1 continuously: after the first sample, one beat per enabled cycle. First tvalid appears 2 cycles after WAIT_FILL exit.
- tready=0: tvalid, tdata, tuser, tlast hold stable. fifo_rden stops once 2 entries are held or in flight, so no data is lost.
- underflow: fifo_rden is never intentionally issued when fifo_empty=1. If a read is nevertheless issued against an empty FIFO, set underflow (sticky until reset). The frame still completes with len_q beats.
- sym_cnt: increments on each tlast beat; saturates at 15. sub_frame_mrkr sets it to 0. If sub_frame_mrkr and a tlast beat occur in the same cycle, result is sym_cnt=0.
- sub_frame_mrkr does not abort a frame in progress.
- fft_len changes outside IDLE are ignored until the next IDLE.
- Arithmetic: all counters are MAX_FFT_LOG2+1 bits and unsigned; no wrap occurs within a frame.

Optional Feature:
Macro: JB_PRACH_FFT_RD_STATUS_EN.
- Defined: adds output frame_cnt (16 bits), which increments on each tlast beat and wraps at 65535 to 0. Adds output max_stall (16 bits), which records the longest run of consecutive tvalid=1, tready=0 cycles and saturates at 65535. Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- fft_len=1024, fifo_count preloaded to 1024, tready=1 -> 1024 consecutive beats, tlast on beat 1024 only, sym_cnt=1, fifo_rden pulses exactly 1024 times, underflow=0.
- fifo_count rising from 0 to 1024 slowly -> tvalid stays 0 until fifo_count=1024, then the first beat arrives 2 cycles later.
- fft_len=64, tready toggled randomly at 50% -> 64 beats in order with no loss or duplication, skid occupancy never exceeds 2, tdata stable while stalled.
- Force fifo_empty=1 mid-READ with fifo_rden issued (via fault injection) -> underflow=1 and stays 1; the frame still ends with tlast after len_q beats.
- Two back-to-back frames, then a sub_frame_mrkr coinciding with the second tlast -> sym_cnt=0.
- reset=0 asserted mid-frame (beat 300 of 1024) -> tvalid=0 and state=IDLE on the next edge. With fifo_count≥1024, a new frame starts normally after reset=1.
